stick_scan_sequencer: RTL and testbench
=======================================

Name: stick_scan_sequencer

Overview:
- Time-multiplexes one shared phase-generator / signal-generator / channel DSP chain across NUM_STICKS drum sticks.
- For each stick in round-robin order it:
  - loads that stick's phase-increment config word;
  - clears the channel;
  - issues a fixed number of evenly spaced sample strobes;
  - collects the channel magnitude and presents it, tagged with the stick index, on an AXI-Stream-style result port.
- Sits between the register/config layer and the DSP chain.

Parameters:
- NUM_STICKS, 2, number of sticks scanned; index width IDX_W = max(1, $clog2(NUM_STICKS)).
- CFG_WIDTH, 13, width of one phase-increment config word.
- MAG_WIDTH, 24, channel magnitude width.
- SAMPLE_DIV, 100, aclk cycles between sample strobes (≥2).
- SAMPLES_PER_SCAN, 64, sample strobes per stick (≥1).
- SETTLE_CYCLES, 16, wait after config load before the first sample period (≥1).
- TIMEOUT_CYCLES, 4096, maximum wait for magnitude_tvalid after the last strobe.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- enable  in  1  run scanning.
- cfg_freq  in  NUM_STICKS*CFG_WIDTH  packed config words; stick i is at bits [i*CFG_WIDTH +: CFG_WIDTH].
- phase_cfg_data  out  CFG_WIDTH  config word to the phase generator.
- phase_tready  out  1  one-cycle sample strobe to the phase generator.
- chan_clear  out  1  one-cycle channel accumulator clear.
- magnitude_tdata  in  MAG_WIDTH  channel result.
- magnitude_tvalid  in  1  channel result valid.
- result_tdata  out  MAG_WIDTH  captured magnitude.
- result_tuser  out  IDX_W  stick index of result.
- result_err  out  1  result produced by timeout.
- result_tvalid  out  1.
- result_tready  in  1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, areset=1): FSM→IDLE, idx=0, all counters 0; all outputs 0, including phase_cfg_data.
- FSM states: IDLE, LOAD, SETTLE, SAMPLE, WAIT_MAG, OUTPUT.
- IDLE: if enable=1 → LOAD with idx=0.
- LOAD (1 cycle):
  - phase_cfg_data <= cfg_freq[idx] (registered; held until the next LOAD);
  - chan_clear=1 for exactly this cycle;
  - → SETTLE.
- SETTLE: count SETTLE_CYCLES cycles → SAMPLE.
- SAMPLE:
  - divider counts 1..SAMPLE_DIV; on the terminal count, phase_tready=1 for one cycle, the divider restarts and the strobe count increments.
  - First strobe occurs in the SAMPLE_DIV-th cycle of SAMPLE.
  - After strobe number SAMPLES_PER_SCAN → WAIT_MAG.
- WAIT_MAG:
  - on magnitude_tvalid=1: capture result_tdata=magnitude_tdata, result_err=0 → OUTPUT.
  - otherwise the timeout counter increments; on reaching TIMEOUT_CYCLES: result_tdata=0, result_err=1 → OUTPUT.
  - magnitude_tvalid outside WAIT_MAG is ignored.
- OUTPUT:
  - result_tvalid=1, result_tuser=idx; tdata/tuser/err held stable until result_tready=1. Backpressure is unbounded and no strobes are issued meanwhile.
  - On handshake, result_tvalid deasserts the next cycle, then:
    - if enable=0 → IDLE, idx=0;
    - else if idx=NUM_STICKS-1 → idx=0, LOAD;
    - else idx+1 → LOAD.
- enable deasserted mid-stick: the current stick completes through OUTPUT, then the FSM goes to IDLE.
- Simultaneous magnitude_tvalid and timeout terminal count in the same cycle: the valid magnitude wins (result_err=0).
- phase_tready and chan_clear are never high in the same cycle.
- areset mid-operation: immediate abort to the reset state; any pending result is lost.
- Per-stick cycles to result_tvalid = 1 + SETTLE_CYCLES + SAMPLES_PER_SCAN*SAMPLE_DIV + (cycles in WAIT_MAG).

Optional Feature:
- Macro: STICK_MASK_EN.
- Defined:
  - adds input port stick_mask [NUM_STICKS-1:0];
  - a masked-off stick (bit=0) is skipped: index selection (from IDLE and after each handshake) picks the next set bit at or after the candidate index, wrapping;
  - if the mask is all zero, the FSM stays in or returns to IDLE with busy=0;
  - the mask is sampled only at index selection.
- Undefined: the port is absent and all sticks are scanned.

Test Plan:
Common parameters: NUM_STICKS=2, SAMPLE_DIV=4, SAMPLES_PER_SCAN=3, SETTLE_CYCLES=2, TIMEOUT_CYCLES=20, cfg_freq={13'h1138,13'h0EB8}.
- Reset/idle: areset=1 then 0, enable=0 → all outputs 0, busy=0, no strobes over 100 cycles.
- Single stick timing: enable=1, magnitude_tvalid pulsed with 24'h00ABCD 5 cycles after the 3rd strobe, result_tready=1 →
  - phase_cfg_data=13'h0EB8;
  - chan_clear one pulse;
  - strobes exactly 4 cycles apart, the first 2+4 cycles after LOAD;
  - result_tdata=24'h00ABCD, tuser=0, err=0.
- Round robin: continuous enable → results with tuser sequence 0,1,0,1; phase_cfg_data alternates 0EB8/1138.
- Backpressure: result_tready=0 for 30 cycles → result_tvalid held with data stable, no phase_tready or chan_clear issued; one transfer on release.
- Timeout: no magnitude_tvalid → after 20 cycles in WAIT_MAG, result_tdata=0, result_err=1; magnitude_tvalid arriving during SAMPLE is ignored.
- Mid-run reset and enable drop:
  - areset during SAMPLE → outputs 0 within the same cycle (async);
  - enable=0 during stick 0 → stick 0 result delivered, then IDLE, and the next run starts at idx 0;
  - with STICK_MASK_EN and mask=2'b10 → only tuser=1 results.

Source files
------------

// File: rtl/stick_scan_sequencer.sv
// -----------------------------------------------------------------------------
// stick_scan_sequencer
//
// Purpose:
//   Time-multiplexes one shared phase-generator / signal-generator / channel
//   DSP chain across NUM_STICKS drum sticks. Sticks are visited in round-robin
//   order. For each stick the sequencer:
//     - loads that stick's phase-increment word;
//     - clears the channel;
//     - waits for the chain to settle;
//     - issues SAMPLES_PER_SCAN evenly spaced sample strobes;
//     - collects the channel magnitude (or times out);
//     - presents the result, tagged with the stick index, on a valid/ready
//       result port.
//
// Optional feature (compile-time macro STICK_MASK_EN):
//   Adds input stick_mask. Sticks whose mask bit is 0 are skipped when the next
//   stick is chosen. An all-zero mask parks the sequencer in IDLE.
//
// Ports:
//   aclk              in   clock
//   areset            in   asynchronous active-high reset
//   enable            in   run scanning
//   cfg_freq          in   packed per-stick phase-increment words
//                          (stick i at [i*CFG_WIDTH +: CFG_WIDTH])
//   stick_mask        in   per-stick enable (STICK_MASK_EN builds only)
//   phase_cfg_data    out  phase-increment word for the current stick
//   phase_tready      out  one-cycle sample strobe
//   chan_clear        out  one-cycle channel accumulator clear
//   magnitude_tdata   in   channel magnitude
//   magnitude_tvalid  in   channel magnitude valid
//   result_tdata      out  captured magnitude (0 on timeout)
//   result_tuser      out  stick index of the result
//   result_err        out  result was produced by the timeout
//   result_tvalid     out  result valid
//   result_tready     in   result accepted
//   busy              out  sequencer is not idle
// -----------------------------------------------------------------------------
module stick_scan_sequencer #(
    parameter int NUM_STICKS       = 2,
    parameter int CFG_WIDTH        = 13,
    parameter int MAG_WIDTH        = 24,
    parameter int SAMPLE_DIV       = 100,
    parameter int SAMPLES_PER_SCAN = 64,
    parameter int SETTLE_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES   = 4096,
    localparam int IDX_W           = (NUM_STICKS > 1) ? $clog2(NUM_STICKS) : 1
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            enable,
    input  logic [NUM_STICKS*CFG_WIDTH-1:0] cfg_freq,
`ifdef STICK_MASK_EN
    input  logic [NUM_STICKS-1:0]           stick_mask,
`endif
    output logic [CFG_WIDTH-1:0]            phase_cfg_data,
    output logic                            phase_tready,
    output logic                            chan_clear,
    input  logic [MAG_WIDTH-1:0]            magnitude_tdata,
    input  logic                            magnitude_tvalid,
    output logic [MAG_WIDTH-1:0]            result_tdata,
    output logic [IDX_W-1:0]                result_tuser,
    output logic                            result_err,
    output logic                            result_tvalid,
    input  logic                            result_tready,
    output logic                            busy
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int DIV_W = $clog2(SAMPLE_DIV + 1);
    localparam int STB_W = $clog2(SAMPLES_PER_SCAN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_PRE     = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_TERM    = DIV_W'(SAMPLE_DIV);
    localparam logic [STB_W-1:0] STB_LAST    = STB_W'(SAMPLES_PER_SCAN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        SAMPLE,
        WAIT_MAG,
        OUTPUT
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [SET_W-1:0]   settle_cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic [STB_W-1:0]   strobe_cnt;
    logic [TMO_W-1:0]   timeout_cnt;

    // Unpacked view of the config words so the stick index selects directly.
    logic [CFG_WIDTH-1:0] cfg_words [NUM_STICKS];

    for (genvar g = 0; g < NUM_STICKS; g++) begin : g_cfg
        assign cfg_words[g] = cfg_freq[g*CFG_WIDTH +: CFG_WIDTH];
    end

    // Returns {found, index}: the first usable stick at or after the
    // candidate, wrapping. Without the mask every stick is usable.
    function automatic logic [IDX_W:0] pick_stick(input int cand);
        int j;
        pick_stick = '0;
`ifdef STICK_MASK_EN
        // Scan downwards so the nearest set bit is the one that sticks.
        for (int k = NUM_STICKS - 1; k >= 0; k--) begin
            j = (cand + k) % NUM_STICKS;
            if (stick_mask[IDX_W'(j)]) begin
                pick_stick = {1'b1, IDX_W'(j)};
            end
        end
`else
        j = cand % NUM_STICKS;
        pick_stick = {1'b1, IDX_W'(j)};
`endif
    endfunction

    logic [IDX_W:0]       pick_first;
    logic [IDX_W:0]       pick_next;
    logic [CFG_WIDTH-1:0] cfg_first;
    logic [CFG_WIDTH-1:0] cfg_next;

    // Candidate selection is resolved combinationally so the FSM below only
    // has to act on the result: from IDLE the search starts at stick 0,
    // after a handshake it starts at the stick after the current one.
    always_comb begin
        pick_first = pick_stick(0);
        pick_next  = pick_stick(int'(idx) + 1);
        cfg_first  = cfg_words[pick_first[IDX_W-1:0]];
        cfg_next   = cfg_words[pick_next[IDX_W-1:0]];
    end

    // Main sequencer. All outputs are registered and are updated on the
    // transition into the state they belong to, so chan_clear is high exactly
    // during LOAD and phase_tready exactly during the terminal divider cycle.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state          <= IDLE;
            idx            <= '0;
            settle_cnt     <= '0;
            div_cnt        <= '0;
            strobe_cnt     <= '0;
            timeout_cnt    <= '0;
            phase_cfg_data <= '0;
            phase_tready   <= 1'b0;
            chan_clear     <= 1'b0;
            result_tdata   <= '0;
            result_tuser   <= '0;
            result_err     <= 1'b0;
            result_tvalid  <= 1'b0;
            busy           <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable && pick_first[IDX_W]) begin
                        idx            <= pick_first[IDX_W-1:0];
                        phase_cfg_data <= cfg_first;
                        chan_clear     <= 1'b1;
                        busy           <= 1'b1;
                        state          <= LOAD;
                    end
                end

                LOAD: begin
                    chan_clear <= 1'b0;
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end

                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        div_cnt    <= DIV_W'(1);
                        strobe_cnt <= '0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end

                // div_cnt holds the 1-based position of the current cycle in
                // the sample period; the strobe is raised one cycle early so
                // that it is visible during the terminal cycle itself.
                SAMPLE: begin
                    if (div_cnt == DIV_TERM) begin
                        phase_tready <= 1'b0;
                        if (strobe_cnt == STB_LAST) begin
                            strobe_cnt  <= '0;
                            div_cnt     <= '0;
                            timeout_cnt <= '0;
                            state       <= WAIT_MAG;
                        end else begin
                            strobe_cnt <= strobe_cnt + STB_W'(1);
                            div_cnt    <= DIV_W'(1);
                        end
                    end else begin
                        phase_tready <= (div_cnt == DIV_PRE);
                        div_cnt      <= div_cnt + DIV_W'(1);
                    end
                end

                // A valid magnitude takes priority over a coincident timeout.
                WAIT_MAG: begin
                    if (magnitude_tvalid) begin
                        result_tdata  <= magnitude_tdata;
                        result_err    <= 1'b0;
                        result_tuser  <= idx;
                        result_tvalid <= 1'b1;
                        state         <= OUTPUT;
                    end else if (timeout_cnt == TMO_LAST) begin
                        result_tdata  <= '0;
                        result_err    <= 1'b1;
                        result_tuser  <= idx;
                        result_tvalid <= 1'b1;
                        state         <= OUTPUT;
                    end else begin
                        timeout_cnt <= timeout_cnt + TMO_W'(1);
                    end
                end

                // Result is held until accepted; a dropped enable only takes
                // effect here, so the current stick always completes.
                OUTPUT: begin
                    if (result_tready) begin
                        result_tvalid <= 1'b0;
                        if (enable && pick_next[IDX_W]) begin
                            idx            <= pick_next[IDX_W-1:0];
                            phase_cfg_data <= cfg_next;
                            chan_clear     <= 1'b1;
                            state          <= LOAD;
                        end else begin
                            idx   <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stick_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stick_scan_sequencer
//
// Directed self-checking bench for stick_scan_sequencer with a small
// configuration (2 sticks, divider 4, 3 strobes, settle 2, timeout 20).
// Relative cycle 0 of a stick is the LOAD cycle (chan_clear high); strobes are
// expected at cycles 6, 10, 14 and the result at 15 + cycles spent waiting for
// the magnitude. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_stick_scan_sequencer;

    localparam int NS    = 2;
    localparam int CW    = 13;
    localparam int MW    = 24;
    localparam int T_MAG = 20;
    localparam int T_TMO = 35;

    logic              aclk;
    logic              areset;
    logic              enable;
    logic [NS*CW-1:0]  cfg_freq;
    logic [NS-1:0]     stick_mask;
    logic [CW-1:0]     phase_cfg_data;
    logic              phase_tready;
    logic              chan_clear;
    logic [MW-1:0]     magnitude_tdata;
    logic              magnitude_tvalid;
    logic [MW-1:0]     result_tdata;
    logic [0:0]        result_tuser;
    logic              result_err;
    logic              result_tvalid;
    logic              result_tready;
    logic              busy;

    int total = 0;
    int bad   = 0;

    stick_scan_sequencer #(
        .NUM_STICKS      (NS),
        .CFG_WIDTH       (CW),
        .MAG_WIDTH       (MW),
        .SAMPLE_DIV      (4),
        .SAMPLES_PER_SCAN(3),
        .SETTLE_CYCLES   (2),
        .TIMEOUT_CYCLES  (20)
    ) dut (
        .aclk            (aclk),
        .areset          (areset),
        .enable          (enable),
        .cfg_freq        (cfg_freq),
`ifdef STICK_MASK_EN
        .stick_mask      (stick_mask),
`endif
        .phase_cfg_data  (phase_cfg_data),
        .phase_tready    (phase_tready),
        .chan_clear      (chan_clear),
        .magnitude_tdata (magnitude_tdata),
        .magnitude_tvalid(magnitude_tvalid),
        .result_tdata    (result_tdata),
        .result_tuser    (result_tuser),
        .result_err      (result_err),
        .result_tvalid   (result_tvalid),
        .result_tready   (result_tready),
        .busy            (busy)
    );

    // Free-running 100 MHz clock.
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Everything the DUT drives, packed for all-zero checks.
    function automatic logic [63:0] allOutputs();
        return {21'd0, phase_cfg_data, phase_tready, chan_clear, result_tdata,
                result_tuser, result_err, result_tvalid, busy};
    endfunction

    // Follows one stick from LOAD to the accepted result.
    //   give_mag : pulse magnitude_tvalid 5 cycles after the last strobe
    //   hold     : cycles of result_tready=0 once the result is presented
    //   spurious : pulse magnitude_tvalid during SAMPLE (must be ignored)
    //   drop_en  : drop enable part-way through the stick
    task automatic runStick(input logic [0:0] exp_idx, input logic [CW-1:0] exp_cfg,
                            input bit give_mag, input logic [MW-1:0] mag,
                            input int hold, input bit spurious, input bit drop_en);
        int t;
        int n;
        int nstrobe;
        int extra_clear;
        int viol;
        logic [MW-1:0] captured;

        if (hold > 0) result_tready = 1'b0;
        n = 0;
        while (!chan_clear && n < 60) begin
            @(negedge aclk);
            n++;
        end
        checkOutput("load_seen", chan_clear, 1'b1);
        checkOutput("load_cfg", phase_cfg_data, exp_cfg);
        checkOutput("load_busy", busy, 1'b1);

        t = 0;
        nstrobe = 0;
        extra_clear = 0;
        while (t < 200) begin
            magnitude_tvalid = 1'b0;
            if (give_mag && t == T_MAG - 1) begin
                magnitude_tvalid = 1'b1;
                magnitude_tdata  = mag;
            end
            if (spurious && t == 8) begin
                magnitude_tvalid = 1'b1;
                magnitude_tdata  = 24'hDEAD00;
            end
            if (drop_en && t == 5) enable = 1'b0;
            @(negedge aclk);
            t++;
            if (phase_tready) begin
                checkOutput("strobe_time", t, 6 + 4 * nstrobe);
                checkOutput("strobe_no_clear", chan_clear, 1'b0);
                nstrobe++;
            end
            if (chan_clear) extra_clear++;
            if (result_tvalid) break;
        end
        magnitude_tvalid = 1'b0;

        checkOutput("result_time", t, give_mag ? T_MAG : T_TMO);
        checkOutput("strobe_count", nstrobe, 3);
        checkOutput("single_clear", extra_clear, 0);
        checkOutput("result_tdata", result_tdata, give_mag ? mag : 24'h0);
        checkOutput("result_tuser", result_tuser, exp_idx);
        checkOutput("result_err", result_err, give_mag ? 1'b0 : 1'b1);

        if (hold > 0) begin
            captured = result_tdata;
            viol = 0;
            for (int h = 0; h < hold; h++) begin
                @(negedge aclk);
                if (!result_tvalid || result_tdata !== captured || result_tuser !== exp_idx
                    || phase_tready || chan_clear) viol++;
            end
            checkOutput("hold_stable", viol, 0);
            result_tready = 1'b1;
        end
        @(negedge aclk);
        checkOutput("valid_drop", result_tvalid, 1'b0);
    endtask

    initial begin
        int act;

        areset           = 1'b1;
        enable           = 1'b0;
        cfg_freq         = {13'h1138, 13'h0EB8};
        stick_mask       = 2'b11;
        magnitude_tdata  = '0;
        magnitude_tvalid = 1'b0;
        result_tready    = 1'b1;

        // Reset and idle behaviour.
        repeat (3) @(negedge aclk);
        checkOutput("reset_outputs", allOutputs(), 64'd0);
        areset = 1'b0;
        act = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (phase_tready || chan_clear || busy || result_tvalid) act++;
        end
        checkOutput("idle_quiet", act, 0);
        checkOutput("idle_outputs", allOutputs(), 64'd0);

        // Single stick timing, then round robin under continuous enable.
        $display("[TB] round robin");
        enable = 1'b1;
        runStick(1'b0, 13'h0EB8, 1'b1, 24'h00ABCD, 0, 1'b0, 1'b0);
        runStick(1'b1, 13'h1138, 1'b1, 24'h111111, 0, 1'b0, 1'b0);
        runStick(1'b0, 13'h0EB8, 1'b1, 24'h222222, 0, 1'b0, 1'b0);
        runStick(1'b1, 13'h1138, 1'b1, 24'h333333, 0, 1'b0, 1'b0);

        // Backpressure on the result port.
        $display("[TB] backpressure");
        runStick(1'b0, 13'h0EB8, 1'b1, 24'h444444, 30, 1'b0, 1'b0);

        // Timeout with an ignored magnitude during SAMPLE.
        $display("[TB] timeout");
        runStick(1'b1, 13'h1138, 1'b0, 24'h0, 0, 1'b1, 1'b0);

        // Enable dropped mid-stick: finish stick 0, park, restart at stick 0.
        $display("[TB] enable drop");
        runStick(1'b0, 13'h0EB8, 1'b1, 24'h555555, 0, 1'b0, 1'b1);
        checkOutput("drop_idle_busy", busy, 1'b0);
        act = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            if (chan_clear || busy) act++;
        end
        checkOutput("drop_idle_quiet", act, 0);
        enable = 1'b1;
        runStick(1'b0, 13'h0EB8, 1'b1, 24'h666666, 0, 1'b0, 1'b0);

        // Asynchronous reset during SAMPLE of stick 1.
        $display("[TB] mid-run reset");
        act = 0;
        while (!chan_clear && act < 60) begin
            @(negedge aclk);
            act++;
        end
        repeat (5) @(negedge aclk);
        checkOutput("pre_reset_busy", busy, 1'b1);
        checkOutput("pre_reset_cfg", phase_cfg_data, 13'h1138);
        #2 areset = 1'b1;
        #1 checkOutput("async_reset_outputs", allOutputs(), 64'd0);
        @(negedge aclk);
        enable = 1'b0;
        areset = 1'b0;
        repeat (5) @(negedge aclk);
        checkOutput("post_reset_outputs", allOutputs(), 64'd0);

`ifdef STICK_MASK_EN
        // Only stick 1 enabled in the mask.
        $display("[TB] stick mask");
        stick_mask = 2'b10;
        enable = 1'b1;
        runStick(1'b1, 13'h1138, 1'b1, 24'h777777, 0, 1'b0, 1'b0);
        runStick(1'b1, 13'h1138, 1'b1, 24'h888888, 0, 1'b0, 1'b1);
        checkOutput("mask_idle_busy", busy, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
